// File: rtl/id_ex_if.sv
// ============================================================================
// id_ex_if -- bundle between the decode/execute environment and id_ex_stage.
//
// Parameters : N    register count (selectors are $clog2(N) bits wide)
//              SIZE datapath word width
//              CW   control-bundle width (bit 0 = is_load)
//
// Signals    : in_valid/in_ready     decode-side handshake
//              ra, rb, rd            source/destination selectors
//              da, db                register-file read data for ra/rb
//              imm, ctrl             decoded immediate and control bundle
//              wb_we, wb_rw, wb_din  write-back port (mirrors register file)
//              flush                 squash the held instruction
//              out_valid/out_ready   execute-side handshake
//              out_a, out_b, out_imm, out_rd, out_ctrl  registered payload
//
// Modports   : master -- environment (drives decode/write-back/out_ready)
//              slave  -- id_ex_stage
// ============================================================================
interface id_ex_if #(
    parameter int N    = 32,
    parameter int SIZE = 64,
    parameter int CW   = 8
);
    localparam int RW = $clog2(N);

    logic            in_valid;
    logic            in_ready;
    logic [RW-1:0]   ra;
    logic [RW-1:0]   rb;
    logic [RW-1:0]   rd;
    logic [SIZE-1:0] da;
    logic [SIZE-1:0] db;
    logic [SIZE-1:0] imm;
    logic [CW-1:0]   ctrl;
    logic            wb_we;
    logic [RW-1:0]   wb_rw;
    logic [SIZE-1:0] wb_din;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_a;
    logic [SIZE-1:0] out_b;
    logic [SIZE-1:0] out_imm;
    logic [RW-1:0]   out_rd;
    logic [CW-1:0]   out_ctrl;

    modport master (
        output in_valid, ra, rb, rd, da, db, imm, ctrl,
               wb_we, wb_rw, wb_din, flush, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_imm, out_rd, out_ctrl
    );

    modport slave (
        input  in_valid, ra, rb, rd, da, db, imm, ctrl,
               wb_we, wb_rw, wb_din, flush, out_ready,
        output in_ready, out_valid, out_a, out_b, out_imm, out_rd, out_ctrl
    );
endinterface

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage -- single-entry ID/EX pipeline register with load-use interlock,
// flush, and optional write-back bypass on operand capture.
//
// Ports      : clk  single clock, rising edge
//              rst  asynchronous, active-high reset
//              bus  id_ex_if.slave (decode handshake, operands, write-back,
//                   flush, execute handshake and registered outputs)
//
// Parameters : N (register count), SIZE (word width), CW (control width,
//              bit 0 = is_load)
//
// Build option: define ID_EX_BYPASS_EN to forward wb_din into out_a/out_b when
//              the write-back targets the source register being read. When
//              undefined, the wb_* inputs are ignored. Register x0 always
//              captures 0 in both builds.
// ============================================================================
module id_ex_stage #(
    parameter int N    = 32,
    parameter int SIZE = 64,
    parameter int CW   = 8
) (
    input  logic    clk,
    input  logic    rst,
    id_ex_if.slave  bus
);
    localparam int RW = $clog2(N);

    logic            out_valid_q;
    logic [SIZE-1:0] out_a_q;
    logic [SIZE-1:0] out_b_q;
    logic [SIZE-1:0] out_imm_q;
    logic [RW-1:0]   out_rd_q;
    logic [CW-1:0]   out_ctrl_q;

    logic            hazard;
    logic            in_ready;
    logic            xfer_in;
    logic            xfer_out;
    logic [SIZE-1:0] a_next;
    logic [SIZE-1:0] b_next;

    // Load-use interlock: the held load's result is not yet available, so an
    // instruction that reads its destination must wait one slot. x0 never
    // creates a dependency.
    assign hazard = out_valid_q && out_ctrl_q[0] && (out_rd_q != '0) &&
                    ((bus.ra == out_rd_q) || (bus.rb == out_rd_q));

    assign in_ready = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign xfer_in  = bus.in_valid && in_ready;
    assign xfer_out = out_valid_q && bus.out_ready;

    // Operand selection at capture time.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        a_next = bus.da;
        b_next = bus.db;
`ifdef ID_EX_BYPASS_EN
        // A write-back landing this same cycle is not yet visible on da/db.
        if (bus.wb_we && (bus.wb_rw == bus.ra)) a_next = bus.wb_din;
        if (bus.wb_we && (bus.wb_rw == bus.rb)) b_next = bus.wb_din;
`endif
        if (bus.ra == '0) a_next = '0;
        if (bus.rb == '0) b_next = '0;
    end

`ifndef ID_EX_BYPASS_EN
    logic wb_unused;
    assign wb_unused = ^{bus.wb_we, bus.wb_rw, bus.wb_din};
`endif

    // Payload registers load only on transfer-in, so they naturally hold
    // during stalls, bubbles and flushes.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the whole payload is reset, not just the valid bit, because
        // all outputs must read 0 while rst is high; non-blocking (<=) keeps
        // every register sampling pre-edge values.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_imm_q   <= '0;
            out_rd_q    <= '0;
            out_ctrl_q  <= '0;
        end else begin
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (xfer_in) begin
                out_valid_q <= 1'b1;
            end else if (xfer_out) begin
                out_valid_q <= 1'b0;
            end

            if (xfer_in) begin
                out_a_q    <= a_next;
                out_b_q    <= b_next;
                out_imm_q  <= bus.imm;
                out_rd_q   <= bus.rd;
                out_ctrl_q <= bus.ctrl;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_ctrl  = out_ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage -- directed self-checking bench for id_ex_stage.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, well away from the next edge.
// ============================================================================
module tb_id_ex_stage;
    logic clk;
    logic rst;

    id_ex_if #(.N(32), .SIZE(64), .CW(8)) bus ();

    id_ex_stage #(.N(32), .SIZE(64), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a_sel, input logic [63:0] a_dat,
                         input logic [4:0] b_sel, input logic [63:0] b_dat,
                         input logic [4:0] d_sel, input logic [63:0] im,
                         input logic [7:0] c);
        bus.in_valid = v;
        bus.ra       = a_sel;
        bus.da       = a_dat;
        bus.rb       = b_sel;
        bus.db       = b_dat;
        bus.rd       = d_sel;
        bus.imm      = im;
        bus.ctrl     = c;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_a"},     bus.out_a,          64'd0);
        check({tag, "_b"},     bus.out_b,          64'd0);
        check({tag, "_imm"},   bus.out_imm,        64'd0);
        check({tag, "_rd"},    64'(bus.out_rd),    64'd0);
        check({tag, "_ctrl"},  64'(bus.out_ctrl),  64'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0, 8'd0);
        bus.wb_we     = 1'b0;
        bus.wb_rw     = 5'd0;
        bus.wb_din    = 64'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state, before any clock edge.
        #2;
        check_all_zero("reset");
        step();
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Basic one-cycle capture.
        drive(1'b1, 5'd5, 64'h11, 5'd6, 64'h22, 5'd7, 64'h100, 8'h02);
        step();
        check("basic_valid", 64'(bus.out_valid), 64'd1);
        check("basic_a",     bus.out_a,          64'h11);
        check("basic_b",     bus.out_b,          64'h22);
        check("basic_rd",    64'(bus.out_rd),    64'd7);
        check("basic_imm",   bus.out_imm,        64'h100);
        check("basic_ctrl",  64'(bus.out_ctrl),  64'h02);

        // Transfer-out with nothing new: bubble, data holds.
        bus.in_valid = 1'b0;
        step();
        check("bubble_valid", 64'(bus.out_valid), 64'd0);
        check("bubble_hold_a", bus.out_a, 64'h11);

        // Backpressure: accept A, stall 3 cycles while inputs change.
        bus.out_ready = 1'b0;
        drive(1'b1, 5'd1, 64'hA1, 5'd2, 64'hB2, 5'd9, 64'h55, 8'h04);
        step();
        check("stall_accept_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd10, 64'hC0 + 64'(i), 5'd12, 64'hD0 + 64'(i), 5'd11, 64'h66, 8'h08);
            #1;
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            step();
            check("stall_hold_a",  bus.out_a,         64'hA1);
            check("stall_hold_b",  bus.out_b,         64'hB2);
            check("stall_hold_rd", 64'(bus.out_rd),   64'd9);
            check("stall_hold_imm", bus.out_imm,      64'h55);
        end
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("swap_valid", 64'(bus.out_valid), 64'd1);
        check("swap_a",     bus.out_a,          64'hC2);
        check("swap_rd",    64'(bus.out_rd),    64'd11);
        check("swap_ctrl",  64'(bus.out_ctrl),  64'h08);

        // Load-use: load to x3, then dependent reading x3.
        drive(1'b1, 5'd4, 64'h44, 5'd6, 64'h66, 5'd3, 64'h0, 8'h01);
        step();
        check("load_rd", 64'(bus.out_rd), 64'd3);
        drive(1'b1, 5'd3, 64'h33, 5'd5, 64'h55, 5'd8, 64'h7, 8'h00);
        #1;
        check("hazard_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        check("hazard_bubble", 64'(bus.out_valid), 64'd0);
        check("hazard_clear_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("dep_valid", 64'(bus.out_valid), 64'd1);
        check("dep_a",     bus.out_a,          64'h33);
        check("dep_rd",    64'(bus.out_rd),    64'd8);

        // A load to x0 creates no dependency.
        drive(1'b1, 5'd2, 64'h2, 5'd2, 64'h2, 5'd0, 64'h0, 8'h01);
        step();
        drive(1'b1, 5'd0, 64'hDEAD, 5'd9, 64'h99, 5'd1, 64'h0, 8'h00);
        #1;
        check("x0_load_no_hazard", 64'(bus.in_ready), 64'd1);
        step();
        check("x0_reads_zero", bus.out_a, 64'd0);

        // Write-back to x4 while reading x4.
        bus.wb_we  = 1'b1;
        bus.wb_rw  = 5'd4;
        bus.wb_din = 64'hABCD;
        drive(1'b1, 5'd2, 64'h77, 5'd4, 64'h1, 5'd5, 64'h0, 8'h00);
        step();
`ifdef ID_EX_BYPASS_EN
        check("wb_bypass_b", bus.out_b, 64'hABCD);
`else
        check("wb_ignored_b", bus.out_b, 64'h1);
`endif
        check("wb_other_a", bus.out_a, 64'h77);
        bus.wb_rw = 5'd0;
        drive(1'b1, 5'd2, 64'h78, 5'd0, 64'h5, 5'd6, 64'h0, 8'h00);
        step();
        check("wb_x0_b", bus.out_b, 64'd0);
        bus.wb_we = 1'b0;

        // Flush with in_valid high and execute stalled.
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        drive(1'b1, 5'd1, 64'hF1, 5'd2, 64'hF2, 5'd12, 64'h0, 8'h00);
        #1;
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_not_accepted_rd", 64'(bus.out_rd), 64'd6);
        bus.flush = 1'b0;
        #1;
        check("post_flush_ready", 64'(bus.in_ready), 64'd1);

        // Asynchronous reset during a stall.
        drive(1'b1, 5'd7, 64'h70, 5'd8, 64'h80, 5'd13, 64'h5A, 8'h10);
        step();
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        drive(1'b1, 5'd9, 64'h90, 5'd10, 64'hA0, 5'd14, 64'h6B, 8'h20);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #2;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("post_rst_valid", 64'(bus.out_valid), 64'd1);
        check("post_rst_rd",    64'(bus.out_rd),    64'd14);
        check("post_rst_a",     bus.out_a,          64'h90);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
